switch_conditioner: RTL

- Per-bit input conditioner for the board switch bank.
- Synchronises each raw switch bit to clk_2, debounces it with a stability counter, and produces clean levels, one-cycle edge pulses and per-bit toggle registers.
- Sits between the raw SWI pins and any logic in top (alarm, siren, greenhouse, aircraft solutions) that needs stable inputs or event strobes instead of raw levels.

---
 rtl/switch_conditioner_if.sv | 23 ++
 rtl/switch_conditioner.sv | 89 ++++++++
 2 files changed

// File: rtl/switch_conditioner_if.sv
// Switch bank bus: raw switch levels in, conditioned levels and event strobes out.
// The conditioner takes the slave modport; whatever drives the raw pins and
// consumes the clean outputs takes the master modport.
interface switch_conditioner_if #(
    parameter int NBITS = 8
);
    logic [NBITS-1:0] swi;      // raw, asynchronous, bouncing levels
    logic [NBITS-1:0] swi_db;   // debounced level per bit
    logic [NBITS-1:0] rise;     // one-cycle pulse after swi_db[i] goes 0->1
    logic [NBITS-1:0] fall;     // one-cycle pulse after swi_db[i] goes 1->0
    logic [NBITS-1:0] toggled;  // inverts on every rise[i]
    logic             changed;  // any rise or fall this cycle

    modport master (
        output swi,
        input  swi_db, rise, fall, toggled, changed
    );

    modport slave (
        input  swi,
        output swi_db, rise, fall, toggled, changed
    );
endinterface

// File: rtl/switch_conditioner.sv
// Per-bit switch conditioner: two-flop synchroniser, stability-count debounce,
// registered rise/fall strobes, per-bit toggle register and an any-change flag.
// Every output comes straight from a flop; swi only ever feeds the first sync stage.
module switch_conditioner #(
    parameter int NBITS         = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk_2,
    input  logic                 reset_n,
    switch_conditioner_if.slave  bus
);
    // Counter is sized from STABLE_CYCLES and only ever counts up to STABLE_CYCLES-1.
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [NBITS-1:0]            s1_q, s1_d;
    logic [NBITS-1:0]            s2_q, s2_d;
    logic [NBITS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0]            swi_db_q, swi_db_d;
    logic [NBITS-1:0]            rise_q, rise_d;
    logic [NBITS-1:0]            fall_q, fall_d;
    logic [NBITS-1:0]            toggled_q, toggled_d;
    logic                        changed_q, changed_d;

    // Next-state: synchronise, then per-bit stability count against the debounced level.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves a
        // value unassigned, which would otherwise infer a latch.
        s1_d      = bus.swi;
        s2_d      = s1_q;
        cnt_d     = cnt_q;
        swi_db_d  = swi_db_q;
        rise_d    = '0;
        fall_d    = '0;
        toggled_d = toggled_q;

        for (int i = 0; i < NBITS; i++) begin
            if (s2_q[i] == swi_db_q[i]) begin
                // Sample agrees with the accepted level: any run in progress is lost.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                // Enough consecutive differing samples: accept the new level.
                swi_db_d[i]  = s2_q[i];
                cnt_d[i]     = '0;
                rise_d[i]    = s2_q[i];
                fall_d[i]    = ~s2_q[i];
                toggled_d[i] = toggled_q[i] ^ s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        changed_d = |(rise_d | fall_d);
    end

    // State register; reset puts every bit at level 0 with no count in progress.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            // NOTE: the counter array is reset along with everything else; a
            // leftover count would let a bit flip early after reset.
            cnt_q     <= '0;
            swi_db_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            toggled_q <= '0;
            changed_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, which is
            // what makes s1 -> s2 a real two-stage synchroniser.
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            cnt_q     <= cnt_d;
            swi_db_q  <= swi_db_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            toggled_q <= toggled_d;
            changed_q <= changed_d;
        end
    end

    assign bus.swi_db  = swi_db_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.toggled = toggled_q;
    assign bus.changed = changed_q;

endmodule
